dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words of storage (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, meaning extra wait cycles before the response (0..7).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address; word index = req_addr[log2(DEPTH)+1:2]; bits [1:0] ignored.
REQ-008 SHALL have port req_mask  input  4  byte-lane write enables, bit n = bits [8n+7:8n].
REQ-009 SHALL have port req_wdata  input  32  lane-aligned store data.
REQ-010 SHALL have port req_ready  output  1  responder can accept a request.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response strobe (load data valid / store ack).
REQ-012 SHALL have port rsp_rdata  output  32  full addressed word for loads; 0 for stores.
REQ-013 SHALL have port rsp_err  output  1  address out of range; qualified by rsp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: req_ready=1; on req_valid capture we/addr/mask/wdata; go WAIT with counter=LATENCY if LATENCY>0, else RESP.
REQ-016 WAIT: req_ready=0; decrement counter each cycle; at counter==1 go RESP.
REQ-017 Entering RESP SHALL perform the access: store writes only lanes with mask bit set; load latches the word into rsp_rdata.
REQ-018 RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE; no back-pressure on response.
REQ-019 Request accepted at edge T SHALL give rsp_valid high in cycle T+LATENCY+1; throughput one request per LATENCY+2 cycles.
REQ-020 req_valid while req_ready=0 SHALL be ignored; requester holds it until accepted.
REQ-021 Load SHALL observe every store whose rsp_valid occurred earlier (read-after-write ordering).
REQ-022 Store with req_mask=0000 SHALL leave memory unchanged and still produce rsp_valid with rsp_err=0.
REQ-023 Load SHALL ignore req_mask and return all four bytes; sign/zero extension is core-side.
REQ-024 req_addr[31:2] >= DEPTH SHALL suppress the write, return rsp_rdata=0, assert rsp_err=1 with rsp_valid.
REQ-025 rsp_rdata and rsp_err SHALL hold their value until the next response; 0 after reset.

Reset
REQ-026 rst SHALL force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 on the next edge.
REQ-027 rst in WAIT SHALL abort the pending request with no memory write and no response.
REQ-028 Memory contents SHALL NOT be cleared by rst.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the request-kind encoding, and DEPTH/LATENCY defaults.
REQ-030 Storage SHALL be sub-module dmem_bram: single-port, DEPTH x 32, 4 byte-write enables, synchronous read, inferable as block RAM.
REQ-031 dmem_responder SHALL contain only the FSM, wait counter, request capture and range check.

Verification
REQ-032 LATENCY=1: store addr 0x10, mask 1111, data 0xDEADBEEF -> ack at T+2; load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 Byte store addr 0x11, mask 0010, data 0x0000AA00 over 0xDEADBEEF -> load 0x10 returns 0xDEADAAEF.
REQ-034 LATENCY=0 then 3: back-to-back requests -> rsp_valid at T+1 / T+4; second request accepted only in IDLE.
REQ-035 DEPTH=1024, load addr 0x00001000 -> rsp_valid, rsp_err=1, rsp_rdata=0; store there changes no word.
REQ-036 Store mask 0000 -> ack, word unchanged; rst asserted in WAIT of store 0x55555555 -> no rsp_valid, old word read back.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder slice.
// Holds the FSM state encoding, the request-kind encoding and parameter defaults.
package dmem_pkg;

  localparam int DEPTH_DEF   = 1024;
  localparam int LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    KIND_LOAD  = 1'b0,
    KIND_STORE = 1'b1
  } req_kind_t;

endpackage

// File: rtl/dmem_bram.sv
// Single-port DEPTH x 32 storage with per-byte write enables and registered read.
// Read-first behaviour; written so synthesis maps it onto block RAM.
module dmem_bram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request capture, wait-state counter, range check and
// a three-state FSM in front of a byte-maskable block RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        enter_resp;

  req_kind_t   kind_q;
  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;

  req_kind_t   acc_kind;
  logic [31:0] acc_addr;
  logic [3:0]  acc_mask;
  logic [31:0] acc_wdata;
  logic        acc_err;

  logic [31:0] bram_rdata;
  logic [31:0] rdata_sel;
  logic [31:0] rdata_hold;
  logic        unused_addr_bits;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 3'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With zero latency the access happens on the accept edge, so use live inputs in IDLE.
  always_comb begin
    if (state == IDLE) begin
      acc_kind  = req_kind_t'(req_we);
      acc_addr  = req_addr;
      acc_mask  = req_mask;
      acc_wdata = req_wdata;
    end else begin
      acc_kind  = kind_q;
      acc_addr  = addr_q;
      acc_mask  = mask_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_err          = |acc_addr[31:AW+2];
  assign unused_addr_bits = ^acc_addr[1:0];

  dmem_bram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bram (
    .clk   (clk),
    .en    (enter_resp && !rst),
    .we    ((acc_kind == KIND_STORE && !acc_err) ? acc_mask : 4'b0000),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (bram_rdata)
  );

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      kind_q  <= req_kind_t'(req_we);
      addr_q  <= req_addr;
      mask_q  <= req_mask;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      rsp_err    <= 1'b0;
      rdata_hold <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (enter_resp) rsp_err <= acc_err;
      if (state == RESP) rdata_hold <= rdata_sel;
    end
  end

  assign rdata_sel = (kind_q == KIND_LOAD && !rsp_err) ? bram_rdata : 32'd0;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? rdata_sel : rdata_hold;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 0, 1 and 3,
// each scenario a task with its own inline comparisons.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        valid    [3];
  logic        we_a     [3];
  logic [31:0] addr_a   [3];
  logic [3:0]  mask_a   [3];
  logic [31:0] wdata_a  [3];
  logic        ready    [3];
  logic        rsp_v    [3];
  logic [31:0] rdata_o  [3];
  logic        err_o    [3];

  int pass_cnt = 0;
  int total    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH   (1024),
      .LATENCY ((g == 2) ? 3 : g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (valid[g]),
      .req_we    (we_a[g]),
      .req_addr  (addr_a[g]),
      .req_mask  (mask_a[g]),
      .req_wdata (wdata_a[g]),
      .req_ready (ready[g]),
      .rsp_valid (rsp_v[g]),
      .rsp_rdata (rdata_o[g]),
      .rsp_err   (err_o[g])
    );
  end

  // Issue one request on instance d and report the response and its latency in edges after accept.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err, output int lat);
    int n;
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    @(negedge clk);
    n = 0;
    while (!ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    valid[d] = 1'b1; we_a[d] = we; addr_a[d] = addr; mask_a[d] = mask; wdata_a[d] = wdata;
    @(posedge clk);
    @(negedge clk);
    valid[d] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_v[d]) begin
        lat = k; rdata = rdata_o[d]; err = err_o[d];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++; if (ready[d] !== 1'b1) $display("FAIL reset_ready[%0d] got %b want 1", d, ready[d]); else pass_cnt++;
      total++; if (rsp_v[d] !== 1'b0) $display("FAIL reset_rsp_valid[%0d] got %b want 0", d, rsp_v[d]); else pass_cnt++;
      total++; if (rdata_o[d] !== 32'd0) $display("FAIL reset_rdata[%0d] got %h want 0", d, rdata_o[d]); else pass_cnt++;
      total++; if (err_o[d] !== 1'b0) $display("FAIL reset_err[%0d] got %b want 0", d, err_o[d]); else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat;
    do_req(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat);
    total++; if (lat !== 1) $display("FAIL store_lat got %0d want 1", lat); else pass_cnt++;
    total++; if (rd !== 32'd0) $display("FAIL store_rdata got %h want 0", rd); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL store_err got %b want 0", e); else pass_cnt++;
    do_req(1, 1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    total++; if (lat !== 1) $display("FAIL load_lat got %0d want 1", lat); else pass_cnt++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata got %h want deadbeef", rd); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL load_err got %b want 0", e); else pass_cnt++;
    @(negedge clk);
    total++; if (rsp_v[1] !== 1'b0) $display("FAIL rsp_one_cycle got %b want 0", rsp_v[1]); else pass_cnt++;
    total++; if (rdata_o[1] !== 32'hDEADBEEF) $display("FAIL rdata_hold got %h want deadbeef", rdata_o[1]); else pass_cnt++;
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic e; int lat;
    do_req(1, 1'b1, 32'h11, 4'b0010, 32'h0000AA00, rd, e, lat);
    total++; if (lat !== 1) $display("FAIL byte_store_lat got %0d want 1", lat); else pass_cnt++;
    do_req(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hDEADAAEF) $display("FAIL byte_merge got %h want deadaaef", rd); else pass_cnt++;
  endtask

  task automatic test_mask_zero();
    logic [31:0] rd; logic e; int lat;
    do_req(1, 1'b1, 32'h10, 4'b0000, 32'h12345678, rd, e, lat);
    total++; if (lat !== 1) $display("FAIL mask0_lat got %0d want 1", lat); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL mask0_err got %b want 0", e); else pass_cnt++;
    do_req(1, 1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hDEADAAEF) $display("FAIL mask0_unchanged got %h want deadaaef", rd); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e; int lat;
    do_req(1, 1'b1, 32'h0, 4'hF, 32'h12345678, rd, e, lat);
    do_req(1, 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, rd, e, lat);
    total++; if (e !== 1'b0) $display("FAIL last_word_err got %b want 0", e); else pass_cnt++;
    do_req(1, 1'b0, 32'h1000, 4'hF, 32'h0, rd, e, lat);
    total++; if (lat !== 1) $display("FAIL oor_load_lat got %0d want 1", lat); else pass_cnt++;
    total++; if (e !== 1'b1) $display("FAIL oor_load_err got %b want 1", e); else pass_cnt++;
    total++; if (rd !== 32'd0) $display("FAIL oor_load_rdata got %h want 0", rd); else pass_cnt++;
    do_req(1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL oor_store_err got %b want 1", e); else pass_cnt++;
    do_req(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h12345678) $display("FAIL oor_no_alias got %h want 12345678", rd); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL err_clears got %b want 0", e); else pass_cnt++;
    do_req(1, 1'b0, 32'hFFC, 4'h0, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL last_word got %h want cafef00d", rd); else pass_cnt++;
  endtask

  // Store then load held back-to-back; the load waits out the busy window.
  task automatic test_back_to_back(input int d, input int lexp, input logic [31:0] a, input logic [31:0] dat);
    int ka, kb, lb;
    logic [31:0] rb;
    ka = -1; kb = -1; lb = -1; rb = 'x;
    @(negedge clk);
    valid[d] = 1'b1; we_a[d] = 1'b1; addr_a[d] = a; mask_a[d] = 4'hF; wdata_a[d] = dat;
    @(posedge clk);
    @(negedge clk);
    we_a[d] = 1'b0; wdata_a[d] = ~dat; mask_a[d] = 4'h0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_v[d] && ka < 0) ka = k;
      if (ready[d]) begin
        kb = k + 1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    valid[d] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_v[d]) begin
        lb = k; rb = rdata_o[d];
        break;
      end
      @(negedge clk);
    end
    total++; if (ka !== lexp) $display("FAIL b2b_first_lat[L%0d] got %0d want %0d", lexp, ka, lexp); else pass_cnt++;
    total++; if (kb !== lexp + 2) $display("FAIL b2b_accept[L%0d] got %0d want %0d", lexp, kb, lexp + 2); else pass_cnt++;
    total++; if (lb !== lexp) $display("FAIL b2b_second_lat[L%0d] got %0d want %0d", lexp, lb, lexp); else pass_cnt++;
    total++; if (rb !== dat) $display("FAIL b2b_raw[L%0d] got %h want %h", lexp, rb, dat); else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic e; int lat; int seen;
    do_req(2, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, rd, e, lat);
    total++; if (lat !== 3) $display("FAIL l3_store_lat got %0d want 3", lat); else pass_cnt++;
    @(negedge clk);
    valid[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 32'h20; mask_a[2] = 4'hF; wdata_a[2] = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    valid[2] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (ready[2] !== 1'b1) $display("FAIL abort_ready got %b want 1", ready[2]); else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_v[2]) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("FAIL abort_no_rsp got %0d responses want 0", seen); else pass_cnt++;
    do_req(2, 1'b0, 32'h20, 4'h0, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h0BADF00D) $display("FAIL abort_no_write got %h want 0badf00d", rd); else pass_cnt++;
    do_req(1, 1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hDEADAAEF) $display("FAIL mem_kept_on_rst got %h want deadaaef", rd); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = 32'd0; mask_a[d] = 4'h0; wdata_a[d] = 32'd0;
    end
    test_reset();
    test_store_load();
    test_byte_store();
    test_mask_zero();
    test_out_of_range();
    test_back_to_back(0, 0, 32'h40, 32'hA5A5_0F0F);
    test_back_to_back(2, 3, 32'h44, 32'h1357_9BDF);
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
